// File: rtl/tl_rx_fc_overflow_tracker.sv
// ---------------------------------------------------------------------------
// tl_rx_fc_overflow_tracker
//
// Receiver-side flow-control overflow tracker. For every received TLP header
// it works out the header and data credits the TLP consumes. It then checks
// them against the advertised limit of the TLP's FC class, using modular
// arithmetic. It also maintains the CREDITS_RECEIVED counters for each class.
//
// A TLP that overflows while checking is enabled is dropped, so its credits
// are not counted. It also raises a one-cycle error pulse and sets a sticky
// status that records the class of the first error.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   tlp_valid             : one-cycle strobe, TLP header present
//   tlp_fc_type           : FC class (0 P, 1 NP, 2 CPL; >= NUM_FC reserved)
//   tlp_has_data          : TLP carries a payload
//   tlp_length_dw         : payload length in DW (0 means 2^PAYLOAD_LENGTH)
//   credit_limit_hdr/data : advertised limits, one field per class
//   inf_hdr/inf_data      : per-class infinite-credit flags
//   receiver_overflow_en  : error check enable
//   status_clear          : clears the sticky status
//   credits_rcv_hdr/data  : CREDITS_RECEIVED counters, one field per class
//   receiver_overflow_error : registered one-cycle error pulse
//   overflow_sticky       : latched error status
//   overflow_fc_type      : class of the first error since the last clear
// ---------------------------------------------------------------------------
module tl_rx_fc_overflow_tracker #(
   parameter int PAYLOAD_LENGTH  = 10,
   parameter int HDR_FIELD_SIZE  = 8,
   parameter int DATA_FIELD_SIZE = 12,
   parameter int NUM_FC          = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 tlp_valid,
   input  logic [1:0]                           tlp_fc_type,
   input  logic                                 tlp_has_data,
   input  logic [PAYLOAD_LENGTH-1:0]            tlp_length_dw,
   input  logic [NUM_FC*HDR_FIELD_SIZE-1:0]     credit_limit_hdr,
   input  logic [NUM_FC*DATA_FIELD_SIZE-1:0]    credit_limit_data,
   input  logic [NUM_FC-1:0]                    inf_hdr,
   input  logic [NUM_FC-1:0]                    inf_data,
   input  logic                                 receiver_overflow_en,
   input  logic                                 status_clear,
   output logic [NUM_FC*HDR_FIELD_SIZE-1:0]     credits_rcv_hdr,
   output logic [NUM_FC*DATA_FIELD_SIZE-1:0]    credits_rcv_data,
   output logic                                 receiver_overflow_error,
   output logic                                 overflow_sticky,
   output logic [1:0]                           overflow_fc_type
);
   localparam int N_H      = HDR_FIELD_SIZE;
   localparam int N_D      = DATA_FIELD_SIZE;
   // log2 of DW per data credit: 4, 16 or 64 DW for N_D 12, 14, 16
   localparam int CR_SHIFT = (N_D == 16) ? 6 : ((N_D == 14) ? 4 : 2);
   localparam int DW_W     = PAYLOAD_LENGTH + 2;
   localparam logic [2:0]     NUM_FC_L = 3'(NUM_FC);
   localparam logic [N_H-1:0] HALF_H   = {1'b1, {(N_H-1){1'b0}}};
   localparam logic [N_D-1:0] HALF_D   = {1'b1, {(N_D-1){1'b0}}};

   typedef enum logic {ST_CLEAN = 1'b0, ST_ERR = 1'b1} state_t;

   // Data credits needed by a TLP; a zero length field with data means the
   // maximum payload.
   function automatic logic [N_D-1:0] data_credits(
      input logic                      has_data,
      input logic [PAYLOAD_LENGTH-1:0] len
   );
      logic [DW_W-1:0] dw;
      logic [DW_W-1:0] rounded;
      if (len == '0) begin
         dw = {2'b01, {PAYLOAD_LENGTH{1'b0}}};
      end else begin
         dw = {2'b00, len};
      end
      rounded = (dw + DW_W'((1 << CR_SHIFT) - 1)) >> CR_SHIFT;
      if (has_data) begin
         return N_D'(rounded);
      end else begin
         return '0;
      end
   endfunction

   logic [NUM_FC-1:0][N_H-1:0] r_rcv_hdr;
   logic [NUM_FC-1:0][N_D-1:0] r_rcv_data;
   logic [NUM_FC-1:0][N_H-1:0] w_lim_hdr_a;
   logic [NUM_FC-1:0][N_D-1:0] w_lim_data_a;
   logic                       r_err;
   logic [1:0]                 r_fc_type;
   state_t                     r_state;
   state_t                     w_state_nxt;

   logic           w_accept;
   logic [N_H-1:0] w_cur_hdr;
   logic [N_D-1:0] w_cur_data;
   logic [N_H-1:0] w_lim_hdr;
   logic [N_D-1:0] w_lim_data;
   logic           w_inf_hdr;
   logic           w_inf_data;
   logic [N_D-1:0] w_req_data;
   logic [N_H-1:0] w_sum_hdr;
   logic [N_D-1:0] w_sum_data;
   logic [N_H-1:0] w_r_hdr;
   logic [N_D-1:0] w_r_data;
   logic           w_ovf_hdr;
   logic           w_ovf_data;
   logic           w_err;
   logic           w_upd;
   logic           w_load_cls;

   assign w_lim_hdr_a  = credit_limit_hdr;
   assign w_lim_data_a = credit_limit_data;

   assign w_accept   = tlp_valid && ({1'b0, tlp_fc_type} < NUM_FC_L);
   assign w_req_data = data_credits(tlp_has_data, tlp_length_dw);
   assign w_sum_hdr  = w_cur_hdr + {{(N_H-1){1'b0}}, 1'b1};
   assign w_sum_data = w_cur_data + w_req_data;
   assign w_r_hdr    = w_lim_hdr - w_sum_hdr;
   assign w_r_data   = w_lim_data - w_sum_data;
   // R equal to half the counter range is still within the window
   assign w_ovf_hdr  = !w_inf_hdr && (w_r_hdr > HALF_H);
   assign w_ovf_data = tlp_has_data && !w_inf_data && (w_r_data > HALF_D);
   assign w_err      = w_accept && (w_ovf_hdr || w_ovf_data) && receiver_overflow_en;
   assign w_upd      = w_accept && !w_err;
   assign w_load_cls = w_err && ((r_state == ST_CLEAN) || status_clear);

   // Select the counters, limits and infinite flags of the addressed class
   always_comb begin
      w_cur_hdr  = '0;
      w_cur_data = '0;
      w_lim_hdr  = '0;
      w_lim_data = '0;
      w_inf_hdr  = 1'b0;
      w_inf_data = 1'b0;
      for (int k = 0; k < NUM_FC; k++) begin
         if (tlp_fc_type == 2'(k)) begin
            w_cur_hdr  = r_rcv_hdr[k];
            w_cur_data = r_rcv_data[k];
            w_lim_hdr  = w_lim_hdr_a[k];
            w_lim_data = w_lim_data_a[k];
            w_inf_hdr  = inf_hdr[k];
            w_inf_data = inf_data[k];
         end else begin
            // other classes keep the current selection
         end
      end
   end

   // CREDITS_RECEIVED counters advance only for accepted, non-dropped TLPs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rcv_hdr  <= '0;
         r_rcv_data <= '0;
      end else begin
         for (int k = 0; k < NUM_FC; k++) begin
            if (w_upd && (tlp_fc_type == 2'(k))) begin
               r_rcv_hdr[k]  <= w_sum_hdr;
               r_rcv_data[k] <= w_sum_data;
            end
         end
      end
   end

   // Status FSM state, error pulse and first-error class
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_CLEAN;
         r_err     <= 1'b0;
         r_fc_type <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err;
         if (w_load_cls) begin
            r_fc_type <= tlp_fc_type;
         end
      end
   end

   // Status FSM next-state: a concurrent error wins over status_clear
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAN: begin
            if (w_err) begin
               w_state_nxt = ST_ERR;
            end else begin
               w_state_nxt = ST_CLEAN;
            end
         end
         ST_ERR: begin
            if (status_clear && !w_err) begin
               w_state_nxt = ST_CLEAN;
            end else begin
               w_state_nxt = ST_ERR;
            end
         end
         default: w_state_nxt = ST_CLEAN;
      endcase
   end

   assign credits_rcv_hdr         = r_rcv_hdr;
   assign credits_rcv_data        = r_rcv_data;
   assign receiver_overflow_error = r_err;
   assign overflow_sticky         = (r_state == ST_ERR);
   assign overflow_fc_type        = r_fc_type;

endmodule

// File: tb/tb_tl_rx_fc_overflow_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for tl_rx_fc_overflow_tracker. The main instance uses the
// defaults (N_H=8, N_D=12). A second instance uses N_D=16 to cover
// 64-DW credit scaling. Expected outputs are queued when a step is driven
// and popped when the result is sampled, one cycle later.
// ---------------------------------------------------------------------------
module tb_tl_rx_fc_overflow_tracker;
   localparam int PL  = 10;
   localparam int NH  = 8;
   localparam int ND  = 12;
   localparam int ND2 = 16;
   localparam int NF  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             tlp_valid;
   logic [1:0]       tlp_fc_type;
   logic             tlp_has_data;
   logic [PL-1:0]    tlp_length_dw;
   logic [NF*NH-1:0] lim_h;
   logic [NF*ND-1:0] lim_d;
   logic [NF-1:0]    inf_h;
   logic [NF-1:0]    inf_d;
   logic             en;
   logic             clr;
   logic [NF*NH-1:0] rcv_h;
   logic [NF*ND-1:0] rcv_d;
   logic             err;
   logic             sticky;
   logic [1:0]       cls;

   logic              v2;
   logic [1:0]        fc2;
   logic              hd2;
   logic [PL-1:0]     len2;
   logic [NF*NH-1:0]  lim_h2;
   logic [NF*ND2-1:0] lim_d2;
   logic [NF-1:0]     inf_h2;
   logic [NF-1:0]     inf_d2;
   logic [NF*NH-1:0]  rcv_h2;
   logic [NF*ND2-1:0] rcv_d2;
   logic              err2;
   logic              sticky2;
   logic [1:0]        cls2;

   tl_rx_fc_overflow_tracker #(
      .PAYLOAD_LENGTH(PL), .HDR_FIELD_SIZE(NH), .DATA_FIELD_SIZE(ND), .NUM_FC(NF)
   ) dut (
      .clk(clk), .rst(rst), .tlp_valid(tlp_valid), .tlp_fc_type(tlp_fc_type),
      .tlp_has_data(tlp_has_data), .tlp_length_dw(tlp_length_dw),
      .credit_limit_hdr(lim_h), .credit_limit_data(lim_d),
      .inf_hdr(inf_h), .inf_data(inf_d), .receiver_overflow_en(en),
      .status_clear(clr), .credits_rcv_hdr(rcv_h), .credits_rcv_data(rcv_d),
      .receiver_overflow_error(err), .overflow_sticky(sticky), .overflow_fc_type(cls)
   );

   tl_rx_fc_overflow_tracker #(
      .PAYLOAD_LENGTH(PL), .HDR_FIELD_SIZE(NH), .DATA_FIELD_SIZE(ND2), .NUM_FC(NF)
   ) dut2 (
      .clk(clk), .rst(rst), .tlp_valid(v2), .tlp_fc_type(fc2),
      .tlp_has_data(hd2), .tlp_length_dw(len2),
      .credit_limit_hdr(lim_h2), .credit_limit_data(lim_d2),
      .inf_hdr(inf_h2), .inf_data(inf_d2), .receiver_overflow_en(en),
      .status_clear(1'b0), .credits_rcv_hdr(rcv_h2), .credits_rcv_data(rcv_d2),
      .receiver_overflow_error(err2), .overflow_sticky(sticky2), .overflow_fc_type(cls2)
   );

   typedef struct {
      string            tag;
      logic             err;
      logic             sticky;
      logic [1:0]       cls;
      logic [NF*NH-1:0] h;
      logic [NF*ND-1:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [NF*NH-1:0] ph(input logic [NH-1:0] p, np, c);
      return {c, np, p};
   endfunction

   function automatic logic [NF*ND-1:0] pd(input logic [ND-1:0] p, np, c);
      return {c, np, p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic drive(input logic v, input logic [1:0] fc, input logic hd,
                        input logic [PL-1:0] len, input logic c);
      tlp_valid     = v;
      tlp_fc_type   = fc;
      tlp_has_data  = hd;
      tlp_length_dw = len;
      clr           = c;
   endtask

   // Drive at a falling edge, queue the expectation, sample at the next one
   task automatic step(input string tag, input logic v, input logic [1:0] fc,
                       input logic hd, input logic [PL-1:0] len, input logic c,
                       input logic e_err, input logic e_st, input logic [1:0] e_cls,
                       input logic [NF*NH-1:0] e_h, input logic [NF*ND-1:0] e_d);
      exp_t e;
      exp_t g;
      drive(v, fc, hd, len, c);
      e.tag = tag; e.err = e_err; e.sticky = e_st; e.cls = e_cls; e.h = e_h; e.d = e_d;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      chk({g.tag, "_err"},    64'(err),    64'(g.err));
      chk({g.tag, "_sticky"}, 64'(sticky), 64'(g.sticky));
      chk({g.tag, "_cls"},    64'(cls),    64'(g.cls));
      chk({g.tag, "_hdr"},    64'(rcv_h),  64'(g.h));
      chk({g.tag, "_data"},   64'(rcv_d),  64'(g.d));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 10'd0, 1'b0);
      lim_h = ph(8'd100, 8'd100, 8'd100);
      lim_d = pd(12'd8, 12'd0, 12'd0);
      inf_h = 3'b000;
      inf_d = 3'b000;
      en    = 1'b1;
      v2 = 1'b0; fc2 = 2'd0; hd2 = 1'b0; len2 = 10'd0;
      lim_h2 = {8'd10, 8'd10, 8'd10};
      lim_d2 = 48'd0;
      inf_h2 = 3'b000;
      inf_d2 = 3'b001;
      #1;
      chk("rst_err",    64'(err),    64'd0);
      chk("rst_sticky", 64'(sticky), 64'd0);
      chk("rst_cls",    64'(cls),    64'd0);
      chk("rst_hdr",    64'(rcv_h),  64'd0);
      chk("rst_data",   64'(rcv_d),  64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 64-DW credits: zero length = 1024 DW = 16 credits, infinite data
      v2 = 1'b1; fc2 = 2'd0; hd2 = 1'b1; len2 = 10'd0;
      @(negedge clk);
      v2 = 1'b0;
      chk("zl_err2",  64'(err2),          64'd0);
      chk("zl_data2", 64'(rcv_d2[15:0]),  64'd16);
      chk("zl_hdr2",  64'(rcv_h2[7:0]),   64'd1);
      // finite data now: 16 + ceil(64/64) = 17 against limit 0 overflows
      inf_d2 = 3'b000;
      v2 = 1'b1; len2 = 10'd64;
      @(negedge clk);
      v2 = 1'b0;
      chk("sc_err2",  64'(err2),          64'd1);
      chk("sc_data2", 64'(rcv_d2[15:0]),  64'd16);

      // P data limit 8: 32 DW fits exactly, then 1 DW gives R=4095
      step("p32",  1'b1, 2'd0, 1'b1, 10'd32, 1'b0, 1'b0, 1'b0, 2'd0, ph(8'd1, 8'd0, 8'd0), pd(12'd8, 12'd0, 12'd0));
      step("p1",   1'b1, 2'd0, 1'b1, 10'd1,  1'b0, 1'b1, 1'b1, 2'd0, ph(8'd1, 8'd0, 8'd0), pd(12'd8, 12'd0, 12'd0));
      step("idle", 1'b0, 2'd0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd0, 8'd0), pd(12'd8, 12'd0, 12'd0));

      // Bring NP header count to 254 with infinite header credits
      inf_h = 3'b010;
      for (int i = 0; i < 254; i++) begin
         drive(1'b1, 2'd1, 1'b0, 10'd0, 1'b0);
         @(negedge clk);
      end
      step("np254", 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd254, 8'd0), pd(12'd8, 12'd0, 12'd0));

      // Wrap-around with NP header limit 3: 255, 0, 1 and no error
      inf_h = 3'b000;
      lim_h = ph(8'd100, 8'd3, 8'd100);
      step("wr255", 1'b1, 2'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd255, 8'd0), pd(12'd8, 12'd0, 12'd0));
      step("wr0",   1'b1, 2'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd0, 8'd0),   pd(12'd8, 12'd0, 12'd0));
      step("wr1",   1'b1, 2'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd1, 8'd0),   pd(12'd8, 12'd0, 12'd0));

      // Check disabled: overflowing CPL TLP still counts, no pulse
      en    = 1'b0;
      lim_h = ph(8'd100, 8'd3, 8'd0);
      step("en0", 1'b1, 2'd2, 1'b1, 10'd4, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));
      en = 1'b1;
      step("rsv", 1'b1, 2'd3, 1'b1, 10'd5, 1'b0, 1'b0, 1'b1, 2'd0, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));

      // NP error concurrent with clear reloads the class; clear alone clears
      lim_h = ph(8'd100, 8'd1, 8'd0);
      step("clrerr", 1'b1, 2'd1, 1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 2'd1, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));
      step("clr",    1'b0, 2'd0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 2'd1, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));
      step("cplerr", 1'b1, 2'd2, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd2, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));
      step("nperr",  1'b1, 2'd1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd2, ph(8'd1, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));

      // R exactly half range is legal; no-data TLP ignores an exhausted data limit
      lim_h = ph(8'd130, 8'd1, 8'd0);
      lim_d = pd(12'd0, 12'd0, 12'd0);
      step("half", 1'b1, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 2'd2, ph(8'd2, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));
      lim_h = ph(8'd132, 8'd1, 8'd0);
      step("half1", 1'b1, 2'd0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 2'd2, ph(8'd2, 8'd1, 8'd1), pd(12'd8, 12'd0, 12'd1));

      // Reset while an erroring TLP is on the inputs
      drive(1'b1, 2'd0, 1'b1, 10'd1, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mrst_err",    64'(err),    64'd0);
      chk("mrst_sticky", 64'(sticky), 64'd0);
      chk("mrst_cls",    64'(cls),    64'd0);
      chk("mrst_hdr",    64'(rcv_h),  64'd0);
      chk("mrst_data",   64'(rcv_d),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      step("postrst", 1'b0, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, ph(8'd0, 8'd0, 8'd0), pd(12'd0, 12'd0, 12'd0));
      lim_h = ph(8'd10, 8'd1, 8'd0);
      step("first", 1'b1, 2'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, ph(8'd1, 8'd0, 8'd0), pd(12'd0, 12'd0, 12'd0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
